// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: UART transmitter, frame = start, DATA_BITS LSB first, optional parity, STOP_BITS stops.
// Define UART_TX_FIFO_EN to buffer words in a FIFO_DEPTH-entry TX FIFO; otherwise words load the shifter directly.
module uart_tx_cfg #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_BITS-1:0]          in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int BIT_TIME = CLK_FREQ / BAUD_RATE;
    localparam int CNT_W    = $clog2(BIT_TIME);
    localparam int IDX_W    = $clog2(DATA_BITS);
    localparam int LVL_W    = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t               state, state_next;
    logic [CNT_W-1:0]     bit_cnt, cnt_next;
    logic [IDX_W-1:0]     bit_idx, idx_next;
    logic                 stop_idx, stop_next;
    logic [DATA_BITS-1:0] shreg, shreg_next;
    logic                 par_bit, par_next;
    logic                 tx_next;
    logic                 bit_end, last_data, last_stop;
    logic                 word_avail, load;
    logic [DATA_BITS-1:0] word;

    assign bit_end   = (bit_cnt == CNT_W'(BIT_TIME - 1));
    assign last_data = (bit_idx == IDX_W'(DATA_BITS - 1));
    assign last_stop = (stop_idx == 1'(STOP_BITS - 1));

`ifdef UART_TX_FIFO_EN
    localparam int AW = LVL_W - 1;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW:0]          wr_ptr, rd_ptr;
    logic [AW:0]          level;
    logic                 full, push;

    // Pointers carry one extra bit so a full FIFO differs from an empty one.
    assign level      = wr_ptr - rd_ptr;
    assign full       = (level == LVL_W'(FIFO_DEPTH));
    assign in_ready   = !full && !rst;
    assign push       = in_valid && in_ready;
    assign word_avail = (level != '0);
    assign word       = mem[rd_ptr[AW-1:0]];
    assign fifo_level = level;

    // NOTE: the storage array has no reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= in_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (load) rd_ptr <= rd_ptr + 1'b1;
        end
    end
`else
    assign in_ready   = (state == S_IDLE) && !rst;
    assign word_avail = in_valid && in_ready;
    assign word       = in_data;
    assign fifo_level = '0;
`endif

    assign busy = (state != S_IDLE) || (fifo_level != '0);

    always_comb begin
        // NOTE: every variable gets a default before the case so no path can infer a latch.
        state_next = state;
        load       = 1'b0;
        cnt_next   = (state == S_IDLE || bit_end) ? '0 : bit_cnt + 1'b1;
        idx_next   = bit_idx;
        stop_next  = stop_idx;
        shreg_next = shreg;
        par_next   = par_bit;
        tx_next    = 1'b1;

        case (state)
            S_IDLE: begin
                if (word_avail) begin
                    state_next = S_START;
                    load       = 1'b1;
                end
            end
            S_START: begin
                if (bit_end) state_next = S_DATA;
            end
            S_DATA: begin
                if (bit_end) begin
                    shreg_next = shreg >> 1;
                    if (last_data) begin
                        idx_next   = '0;
                        state_next = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        idx_next = bit_idx + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) state_next = S_STOP;
            end
            S_STOP: begin
                if (bit_end) begin
                    if (last_stop) begin
                        stop_next = 1'b0;
                        // Chain straight into the next start bit when a word is waiting.
                        if (word_avail) begin
                            state_next = S_START;
                            load       = 1'b1;
                        end else begin
                            state_next = S_IDLE;
                        end
                    end else begin
                        stop_next = stop_idx + 1'b1;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase

        if (load) begin
            shreg_next = word;
            par_next   = (^word) ^ (PARITY == 2);
        end

        // tx is registered from the next state so each level starts on the edge that enters it.
        case (state_next)
            S_START:  tx_next = 1'b0;
            S_DATA:   tx_next = shreg_next[0];
            S_PARITY: tx_next = par_next;
            default:  tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (rst) begin
            state    <= S_IDLE;
            bit_cnt  <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            tx       <= 1'b1;
        end else begin
            state    <= state_next;
            bit_cnt  <= cnt_next;
            bit_idx  <= idx_next;
            stop_idx <= stop_next;
            tx       <= tx_next;
        end
    end

    always_ff @(posedge clk) begin
        shreg   <= shreg_next;
        par_bit <= par_next;
    end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb_uart_tx_cfg: self-checking bench for uart_tx_cfg with 8N1, 7E2 and 7O2 instances at BIT_TIME = 10.
// Adapts its timing expectations to whether UART_TX_FIFO_EN is defined.
module tb_uart_tx_cfg;
    localparam int BIT_TIME = 10;
    localparam int N_RAND   = 30;
`ifdef UART_TX_FIFO_EN
    localparam int START_LAT = 1;
    localparam int NQ        = 5;
`else
    localparam int START_LAT = 0;
    localparam int NQ        = 1;
`endif

    logic       clk;
    logic       rst;
    logic [2:0] in_valid_v;
    logic [7:0] in_data_v [3];
    wire  [2:0] ready_v;
    wire  [2:0] tx_v;
    wire  [2:0] busy_v;
    wire  [4:0] level_v [3];

    int n_total = 0;
    int n_pass  = 0;

    uart_tx_cfg #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8), .PARITY(0),
                  .STOP_BITS(1), .FIFO_DEPTH(16)) dut_a (
        .clk(clk), .rst(rst), .in_data(in_data_v[0]), .in_valid(in_valid_v[0]),
        .in_ready(ready_v[0]), .tx(tx_v[0]), .busy(busy_v[0]), .fifo_level(level_v[0]));

    uart_tx_cfg #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(7), .PARITY(1),
                  .STOP_BITS(2), .FIFO_DEPTH(16)) dut_b (
        .clk(clk), .rst(rst), .in_data(in_data_v[1][6:0]), .in_valid(in_valid_v[1]),
        .in_ready(ready_v[1]), .tx(tx_v[1]), .busy(busy_v[1]), .fifo_level(level_v[1]));

    uart_tx_cfg #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(7), .PARITY(2),
                  .STOP_BITS(2), .FIFO_DEPTH(16)) dut_c (
        .clk(clk), .rst(rst), .in_data(in_data_v[2][6:0]), .in_valid(in_valid_v[2]),
        .in_ready(ready_v[2]), .tx(tx_v[2]), .busy(busy_v[2]), .fifo_level(level_v[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #800_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int          sel;
        logic [7:0]  word;
        logic [31:0] frame;
        int          len;
    } vec_t;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Reference frame: start 0, data LSB first, parity from the count of ones, then stop 1s.
    function automatic logic [31:0] model_frame(input logic [7:0] w, input int dbits, input int par,
                                                input int stops, output int len);
        bit bits [$];
        int ones;
        ones = 0;
        bits.push_back(1'b0);
        for (int i = 0; i < dbits; i++) begin
            bits.push_back(w[i]);
            ones += int'(w[i]);
        end
        if (par == 1) bits.push_back(bit'(ones % 2));
        else if (par == 2) bits.push_back(bit'((ones + 1) % 2));
        for (int i = 0; i < stops; i++) bits.push_back(1'b1);
        len = bits.size();
        model_frame = '0;
        foreach (bits[i]) model_frame[i] = bits[i];
    endfunction

    task automatic send(input int sel, input logic [7:0] w, output bit ok);
        int n;
        n = 0;
        in_data_v[sel]  = w;
        in_valid_v[sel] = 1'b1;
        while (ready_v[sel] !== 1'b1 && n < 2000) begin
            tick();
            n++;
        end
        ok = (ready_v[sel] === 1'b1);
        tick();
        in_valid_v[sel] = 1'b0;
    endtask

    task automatic wait_start(input int sel, input int max_cyc, output int waited);
        waited = 0;
        while (tx_v[sel] !== 1'b0 && waited < max_cyc) begin
            tick();
            waited++;
        end
    endtask

    // Starts on the first start-bit sample; bit 31 of act flags a level that did not hold for BIT_TIME.
    task automatic check_frame(input int sel, input int len, output logic [31:0] act);
        act = '0;
        for (int b = 0; b < len; b++) begin
            logic v;
            v = 1'b0;
            for (int c = 0; c < BIT_TIME; c++) begin
                if (!(b == 0 && c == 0)) tick();
                if (c == 0) v = tx_v[sel];
                else if (tx_v[sel] !== v) act[31] = 1'b1;
            end
            act[b] = v;
        end
    endtask

    vec_t       vecs [8];
    logic [7:0] rnd_q [$];

    initial begin
        int          n, len, bad_tx, bad_busy;
        bit          ok;
        logic [31:0] act, exp;

        vecs[0] = '{0, 8'h55, 32'h2AA, 10};
        vecs[1] = '{0, 8'h00, 32'h200, 10};
        vecs[2] = '{0, 8'hFF, 32'h3FE, 10};
        vecs[3] = '{0, 8'hA3, 32'h346, 10};
        vecs[4] = '{1, 8'h41, 32'h682, 11};
        vecs[5] = '{2, 8'h41, 32'h782, 11};
        vecs[6] = '{1, 8'h7F, 32'h7FE, 11};
        vecs[7] = '{2, 8'h7F, 32'h6FE, 11};

        rst        = 1'b1;
        in_valid_v = '0;
        for (int i = 0; i < 3; i++) in_data_v[i] = '0;
        repeat (3) tick();
        check("rst_ready_low", 32'(ready_v), 32'd0);
        check("rst_tx_high", 32'(tx_v), 32'h7);
        check("rst_busy_low", 32'(busy_v), 32'd0);
        check("rst_level_zero", 32'(level_v[0]), 32'd0);

        rst = 1'b0;
        tick();
        check("ready_after_rst", 32'(ready_v), 32'h7);
        bad_tx   = 0;
        bad_busy = 0;
        for (int c = 0; c < 1000; c++) begin
            if (tx_v !== 3'b111) bad_tx++;
            if (busy_v !== 3'b000) bad_busy++;
            tick();
        end
        check("idle_tx_cycles_low", 32'(bad_tx), 32'd0);
        check("idle_busy_cycles_high", 32'(bad_busy), 32'd0);

        foreach (vecs[i]) begin
            send(vecs[i].sel, vecs[i].word, ok);
            check("vec_accept", 32'(ok), 32'd1);
            wait_start(vecs[i].sel, 50, n);
            check("vec_start_latency", 32'(n), 32'(START_LAT));
            check_frame(vecs[i].sel, vecs[i].len, act);
            check("vec_frame", act, vecs[i].frame);
            check("vec_busy_last_stop", 32'(busy_v[vecs[i].sel]), 32'd1);
            tick();
            check("vec_busy_fall_tx_idle", 32'({busy_v[vecs[i].sel], tx_v[vecs[i].sel]}), 32'b01);
        end

        fork
            begin : rnd_drv
                for (int i = 0; i < N_RAND; i++) begin
                    logic [7:0] w;
                    bit         sent;
                    int         gap;
                    w   = 8'($urandom_range(0, 255));
                    gap = ($urandom_range(0, 7) == 0) ? int'($urandom_range(50, 250))
                                                     : int'($urandom_range(0, 3));
                    repeat (gap) tick();
                    rnd_q.push_back(w);
                    send(0, w, sent);
                    check("rand_accept", 32'(sent), 32'd1);
                end
            end
            begin : rnd_chk
                for (int k = 0; k < N_RAND; k++) begin
                    int          wn, flen;
                    logic [31:0] ract, rexp;
                    logic [7:0]  w;
                    wait_start(0, 1000, wn);
                    check("rand_start_seen", 32'(tx_v[0]), 32'd0);
                    if (tx_v[0] !== 1'b0) break;
                    check("rand_queue_nonempty", 32'(rnd_q.size() != 0), 32'd1);
                    w    = (rnd_q.size() != 0) ? rnd_q.pop_front() : 8'h00;
                    rexp = model_frame(w, 8, 0, 1, flen);
                    check_frame(0, flen, ract);
                    check("rand_frame", ract, rexp);
                    tick();
                end
            end
        join

`ifdef UART_TX_FIFO_EN
        fork
            begin : burst_drv
                int  idx, guard;
                bit  hs;
                idx = 0;
                in_data_v[0]  = 8'h00;
                in_valid_v[0] = 1'b1;
                for (int c = 0; c < 30; c++) begin
                    hs = (ready_v[0] === 1'b1);
                    tick();
                    if (hs) begin
                        idx++;
                        in_data_v[0] = 8'(idx);
                    end
                end
                check("burst_accepted_before_full", 32'(idx), 32'd17);
                check("burst_full_ready_low", 32'(ready_v[0]), 32'd0);
                check("burst_full_level", 32'(level_v[0]), 32'd16);
                guard = 0;
                while (idx < 20 && guard < 5000) begin
                    hs = (ready_v[0] === 1'b1);
                    tick();
                    guard++;
                    if (hs) begin
                        idx++;
                        in_data_v[0] = 8'(idx);
                    end
                end
                in_valid_v[0] = 1'b0;
                check("burst_all_accepted", 32'(idx), 32'd20);
            end
            begin : burst_chk
                int gaps_bad;
                gaps_bad = 0;
                for (int k = 0; k < 20; k++) begin
                    int          wn, flen;
                    logic [31:0] bact, bexp;
                    wait_start(0, 300, wn);
                    check("burst_start_seen", 32'(tx_v[0]), 32'd0);
                    if (tx_v[0] !== 1'b0) break;
                    if (k > 0 && wn != 0) gaps_bad++;
                    if (k == 1) begin
                        check("burst_no_pushthrough_level", 32'(level_v[0]), 32'd15);
                        check("burst_ready_after_pop", 32'(ready_v[0]), 32'd1);
                    end
                    bexp = model_frame(8'(k), 8, 0, 1, flen);
                    check_frame(0, flen, bact);
                    check("burst_frame", bact, bexp);
                    tick();
                end
                check("burst_interframe_gaps", 32'(gaps_bad), 32'd0);
            end
        join
        check("burst_end_busy", 32'(busy_v[0]), 32'd0);
        check("burst_end_level", 32'(level_v[0]), 32'd0);
`else
        fork
            begin : b2b_drv
                bit sent;
                send(0, 8'h5A, sent);
                check("b2b_accept_first", 32'(sent), 32'd1);
                send(0, 8'hC3, sent);
                check("b2b_accept_second", 32'(sent), 32'd1);
            end
            begin : b2b_chk
                int          wn, flen;
                logic [31:0] bact, bexp;
                wait_start(0, 50, wn);
                bexp = model_frame(8'h5A, 8, 0, 1, flen);
                check_frame(0, flen, bact);
                check("b2b_frame_first", bact, bexp);
                check("b2b_level_mid", 32'(level_v[0]), 32'd0);
                tick();
                wait_start(0, 50, wn);
                check("b2b_idle_gap_at_least_one", 32'(wn >= 1), 32'd1);
                check("b2b_level_second", 32'(level_v[0]), 32'd0);
                bexp = model_frame(8'hC3, 8, 0, 1, flen);
                check_frame(0, flen, bact);
                check("b2b_frame_second", bact, bexp);
                tick();
            end
        join
`endif

        // Reset mid-frame: truncate a frame during its 4th data bit with further words queued.
        send(0, 8'hC3, ok);
        wait_start(0, 50, n);
        for (int q = 1; q < NQ; q++) send(0, 8'(q), ok);
        check("mid_level_before_rst", 32'(level_v[0]), 32'(NQ - 1));
        repeat (44 - (NQ - 1)) tick();
        check("mid_tx_data_bit3", 32'(tx_v[0]), 32'd0);
        rst = 1'b1;
        tick();
        check("mid_rst_tx", 32'(tx_v[0]), 32'd1);
        check("mid_rst_busy", 32'(busy_v[0]), 32'd0);
        check("mid_rst_level", 32'(level_v[0]), 32'd0);
        check("mid_rst_ready", 32'(ready_v[0]), 32'd0);
        rst = 1'b0;
        bad_tx   = 0;
        bad_busy = 0;
        for (int c = 0; c < 300; c++) begin
            tick();
            if (tx_v[0] !== 1'b1) bad_tx++;
            if (busy_v[0] !== 1'b0) bad_busy++;
        end
        check("post_rst_tx_cycles_low", 32'(bad_tx), 32'd0);
        check("post_rst_busy_cycles_high", 32'(bad_busy), 32'd0);
        check("post_rst_ready", 32'(ready_v[0]), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
